// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART TX arbiter.
package uart_arb_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_e;

    localparam int BYTE_W          = 8;
    localparam int BAUD_DIV        = 868;
    localparam int WDOG_CYCLES_DEF = 10 * BAUD_DIV * 10;

    function automatic int wrap_add(int base, int off, int n);
        return (base + off) % n;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester/serializer handshake bundle for uart_tx_arbiter.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 2
);
    import uart_arb_pkg::*;

    localparam int GW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*BYTE_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_last;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      tx_valid;
    logic [BYTE_W-1:0]         tx_data;
    logic                      tx_ready;
    logic [GW-1:0]             grant_id;
    logic                      busy;
    logic                      wdog_expired;

    modport master (
        output req_valid, req_data, req_last, tx_ready,
        input  req_ready, tx_valid, tx_data,
        input  grant_id, busy, wdog_expired
    );

    modport slave (
        input  req_valid, req_data, req_last, tx_ready,
        output req_ready, tx_valid, tx_data,
        output grant_id, busy, wdog_expired
    );

endinterface

// File: rtl/uart_rr_pick.sv
// Rotate-priority picker: first asserted request after last_grant.
module uart_rr_pick
    import uart_arb_pkg::*;
#(
    parameter  int N  = 2,
    localparam int GW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [GW-1:0] last_grant,
    output logic [GW-1:0] pick,
    output logic          any
);

    logic [GW-1:0] idx;

    always_comb begin
        pick = '0;
        any  = 1'b0;
        idx  = '0;
        // Farthest first, so the nearest requester overwrites last.
        for (int i = N; i >= 1; i--) begin
            idx = GW'(wrap_add(int'(last_grant), i, N));
            if (req[idx]) begin
                pick = idx;
                any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter in front of the UART TX serializer.
// Optional idle watchdog on a locked requester: UART_TX_ARB_WDOG_EN.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int WDOG_CYCLES = WDOG_CYCLES_DEF
) (
    input logic              clk,
    input logic              rst_n,
    uart_tx_arbiter_if.slave bus
);

    localparam int         GW      = $clog2(NUM_REQ);
    localparam logic [0:0] ST_IDLE = IDLE;
    localparam logic [0:0] ST_LOCK = LOCK;

    logic [0:0]        state;
    logic [GW-1:0]     grant;
    logic [GW-1:0]     last_grant;
    logic [GW-1:0]     pick;
    logic              any;
    logic              busy_q;
    logic              tx_valid_q;
    logic [BYTE_W-1:0] tx_data_q;
    logic [BYTE_W-1:0] g_data;
    logic              g_valid;
    logic              g_last;
    logic              hold_free;
    logic              accept;
    logic              release_lock;
    logic              wdog_hit;

    uart_rr_pick #(.N(NUM_REQ)) u_pick (
        .req        (bus.req_valid),
        .last_grant (last_grant),
        .pick       (pick),
        .any        (any)
    );

    assign g_valid      = bus.req_valid[grant];
    assign g_last       = bus.req_last[grant];
    assign g_data       = bus.req_data[int'(grant)*BYTE_W +: BYTE_W];
    assign hold_free    = !tx_valid_q || bus.tx_ready;
    assign accept       = (state == ST_LOCK) && g_valid && hold_free;
    assign release_lock = (accept && g_last) || wdog_hit;

    always_comb begin
        bus.req_ready = '0;
        if (state == ST_LOCK) bus.req_ready[grant] = hold_free;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            grant      <= '0;
            last_grant <= GW'(NUM_REQ - 1);
            busy_q     <= 1'b0;
        end else begin
            unique case (1'b1)
                (state == ST_IDLE): begin
                    if (any) begin
                        grant  <= pick;
                        busy_q <= 1'b1;
                        state  <= ST_LOCK;
                    end
                end
                release_lock: begin
                    last_grant <= grant;
                    busy_q     <= 1'b0;
                    state      <= ST_IDLE;
                end
                default: ;
            endcase
        end
    end

    // Single holding register; drains independently of the lock state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
        end else if (accept) begin
            tx_valid_q <= 1'b1;
            tx_data_q  <= g_data;
        end else if (bus.tx_ready) begin
            tx_valid_q <= 1'b0;
        end
    end

`ifdef UART_TX_ARB_WDOG_EN
    localparam int CW = $clog2(WDOG_CYCLES) + 1;

    logic [CW-1:0] wdog_cnt;
    logic          wdog_q;

    assign wdog_hit = (state == ST_LOCK) && !g_valid &&
                      (wdog_cnt == CW'(WDOG_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_cnt <= '0;
            wdog_q   <= 1'b0;
        end else begin
            wdog_q <= wdog_hit;
            if (state == ST_IDLE || accept) begin
                wdog_cnt <= '0;
            end else if (!g_valid && !wdog_hit) begin
                wdog_cnt <= wdog_cnt + 1'b1;
            end
        end
    end

    assign bus.wdog_expired = wdog_q;
`else
    logic unused_wdog;

    assign unused_wdog      = (WDOG_CYCLES > 0);
    assign wdog_hit         = 1'b0;
    assign bus.wdog_expired = 1'b0;
`endif

    assign bus.tx_valid = tx_valid_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.grant_id = grant;
    assign bus.busy     = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with two requesters.
module tb_uart_tx_arbiter;
    import uart_arb_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;

    logic [8:0] q0[$];
    logic [8:0] q1[$];
    logic [7:0] got[$];

    uart_tx_arbiter_if #(.NUM_REQ(2)) bus ();

    uart_tx_arbiter #(
        .NUM_REQ     (2),
        .WDOG_CYCLES (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got_v,
                         input logic [31:0] exp_v);
        n_cmp++;
        if (got_v !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got_v, exp_v);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_last  = '0;
        bus.tx_ready  = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drive();
        bus.req_valid = '0;
        bus.req_last  = '0;
        bus.req_data  = '0;
        if (q0.size() != 0) begin
            bus.req_valid[0]   = 1'b1;
            bus.req_last[0]    = q0[0][8];
            bus.req_data[7:0]  = q0[0][7:0];
        end
        if (q1.size() != 0) begin
            bus.req_valid[1]   = 1'b1;
            bus.req_last[1]    = q1[0][8];
            bus.req_data[15:8] = q1[0][7:0];
        end
    endtask

    task automatic run(input string tag, input int budget);
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || bus.tx_valid) &&
               n < budget) begin
            drive();
            #1;
            if (bus.tx_valid && bus.tx_ready) got.push_back(bus.tx_data);
            if (bus.req_valid[0] && bus.req_ready[0]) begin
                check({tag, "_gid0"}, bus.grant_id, 0);
                void'(q0.pop_front());
            end
            if (bus.req_valid[1] && bus.req_ready[1]) begin
                check({tag, "_gid1"}, bus.grant_id, 1);
                void'(q1.pop_front());
            end
            @(negedge clk);
            n++;
        end
        bus.req_valid = '0;
        check({tag, "_done"}, n < budget, 1);
    endtask

    task automatic cmp_got(input string tag, input logic [7:0] e0,
                           input logic [7:0] e1, input logic [7:0] e2,
                           input logic [7:0] e3);
        logic [7:0] exp_b [4];
        exp_b = '{e0, e1, e2, e3};
        for (int i = 0; i < 4; i++) begin
            check(tag, (i < got.size()) ? {24'h0, got[i]} : 32'hdead,
                  {24'h0, exp_b[i]});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        int first;

        rst_n         = 1'b0;
        bus.tx_ready  = 1'b1;
        bus.req_valid = 2'b01;
        bus.req_data  = 16'h0041;
        bus.req_last  = 2'b01;
        repeat (3) @(negedge clk);
        check("rst_txv", bus.tx_valid, 0);
        check("rst_rdy", bus.req_ready, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_gid", bus.grant_id, 0);
        check("rst_wdog", bus.wdog_expired, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("r_busy", bus.busy, 1);
        check("r_gid", bus.grant_id, 0);
        check("r_rdy", bus.req_ready, 2'b01);
        check("r_txv0", bus.tx_valid, 0);
        @(negedge clk);
        check("r_txv", bus.tx_valid, 1);
        check("r_txd", bus.tx_data, 8'h41);
        check("r_idle", bus.busy, 0);
        bus.req_valid = '0;
        @(negedge clk);
        check("r_drain", bus.tx_valid, 0);

        do_reset();
        got.delete();
        q0 = '{9'h048, 9'h149};
        q1 = '{9'h04F, 9'h14B};
        run("sim", 50);
        check("sim_n", got.size(), 4);
        cmp_got("sim_byte", 8'h48, 8'h49, 8'h4F, 8'h4B);

        do_reset();
        bus.tx_ready     = 1'b0;
        bus.req_valid    = 2'b01;
        bus.req_data     = 16'h0055;
        bus.req_last     = 2'b00;
        @(negedge clk);
        #1 check("bp_rdy_lock", bus.req_ready[0], 1);
        @(negedge clk);
        bus.req_data[7:0] = 8'h56;
        bus.req_last      = 2'b01;
        for (int k = 0; k < 20; k++) begin
            #1;
            check("bp_hold", bus.tx_data, 8'h55);
            check("bp_rdy", {bus.tx_valid, bus.req_ready[0]}, 2'b10);
            @(negedge clk);
        end
        bus.tx_ready = 1'b1;
        #1 check("bp_rel_rdy", bus.req_ready[0], 1);
        @(negedge clk);
        check("bp_next_v", bus.tx_valid, 1);
        check("bp_next_d", bus.tx_data, 8'h56);
        check("bp_idle", bus.busy, 0);
        bus.req_valid = '0;
        @(negedge clk);
        check("bp_drain", bus.tx_valid, 0);

        do_reset();
        got.delete();
        q0 = '{9'h1A0, 9'h1A0, 9'h1A0, 9'h1A0};
        q1 = '{9'h1B0, 9'h1B0, 9'h1B0, 9'h1B0};
        run("fair", 100);
        check("fair_n", got.size(), 8);
        for (int i = 0; i < 8; i++) begin
            check("fair_byte", (i < got.size()) ? {24'h0, got[i]} : 32'hdead,
                  (i % 2 == 0) ? 32'hA0 : 32'hB0);
        end

        do_reset();
        bus.tx_ready  = 1'b0;
        bus.req_valid = 2'b10;
        bus.req_data  = 16'h7700;
        bus.req_last  = 2'b00;
        @(negedge clk);
        check("mr_gid", bus.grant_id, 1);
        check("mr_busy", bus.busy, 1);
        @(negedge clk);
        check("mr_txv", bus.tx_valid, 1);
        bus.req_valid = '0;
        #2 rst_n = 1'b0;
        #1;
        check("mr_async_txv", bus.tx_valid, 0);
        check("mr_async_busy", bus.busy, 0);
        @(negedge clk);
        rst_n        = 1'b1;
        bus.tx_ready = 1'b1;
        got.delete();
        q0 = '{9'h110};
        q1 = '{9'h120};
        run("mr", 50);
        check("mr_n", got.size(), 2);
        check("mr_first", (got.size() > 0) ? {24'h0, got[0]} : 32'hdead, 8'h10);

        do_reset();
        bus.req_valid = 2'b10;
        bus.req_data  = 16'h3100;
        bus.req_last  = 2'b00;
        @(negedge clk);
        @(negedge clk);
        check("wd_txd", bus.tx_data, 8'h31);
        bus.req_valid = 2'b01;
        bus.req_data  = 16'h0032;
        bus.req_last  = 2'b01;
`ifdef UART_TX_ARB_WDOG_EN
        first = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (bus.wdog_expired) begin
                first = k;
                break;
            end
        end
        check("wd_when", first, 16);
        check("wd_idle", bus.busy, 0);
        @(negedge clk);
        check("wd_pulse", bus.wdog_expired, 0);
        check("wd_gid", bus.grant_id, 0);
        check("wd_busy", bus.busy, 1);
        @(negedge clk);
        check("wd_txd0", bus.tx_data, 8'h32);
        check("wd_txv0", bus.tx_valid, 1);
        bus.req_valid = '0;
        @(negedge clk);
`else
        first = 0;
        repeat (1000) begin
            @(negedge clk);
            if (bus.wdog_expired) first++;
        end
        check("lk_pulses", first, 0);
        check("lk_busy", bus.busy, 1);
        check("lk_gid", bus.grant_id, 1);
        check("lk_rdy0", bus.req_ready[0], 0);
`endif
        do_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
